imem_load_ctrl: RTL

- Boot/reload sequencer for the word-addressed 4 KB instruction memory (1024 x 32, combinational read port feeding IF).
- On a start request it stalls the pipeline, zero-fills the whole memory, then streams program words in via a valid/ready port to sequential word addresses.
- Once loading completes it pulses the PC-load so fetch begins at the boot address, then releases the pipeline.
- Sits between the host/loader interface, the instruction memory write port and the pipeline hazard/PC logic.

---
 rtl/imem_load_ctrl.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/imem_load_ctrl.sv
// imem_load_ctrl: boot/reload sequencer for the word-addressed instruction
// memory. On start it stalls the CPU, zero-fills every word, then streams
// program words from a valid/ready port to sequential addresses.
// When loading is finished it pulses pc_load and releases the pipeline.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   start             request a (re)load
//   load_valid/ready  program word handshake
//   load_data         program word
//   load_last         final word of the program
//   im_we/waddr/wdata instruction memory write port
//   cpu_stall         freezes PC/IF/ID
//   pc_load, pc_init  one-cycle PC load pulse and boot address
//   done, err         running / load aborted
//   word_count        words accepted in the current load
//
// Optional feature macro IMEM_LOAD_CHECKSUM_EN:
//   adds expected_sum input and chk_err output. The load is aborted
//   if the modulo-2^32 sum of the program words differs from expected_sum.
module imem_load_ctrl #(
   parameter int          WIDTH        = 32,
   parameter int          ADDR_WIDTH   = 10,
   parameter int          NUM          = 1024,
   parameter logic [31:0] INIT_ADDRESS = 32'h0000_0c00
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  load_valid,
   input  logic [WIDTH-1:0]      load_data,
   input  logic                  load_last,
`ifdef IMEM_LOAD_CHECKSUM_EN
   input  logic [31:0]           expected_sum,
   output logic [0:0]            chk_err,
`endif
   output logic                  load_ready,
   output logic                  im_we,
   output logic [ADDR_WIDTH-1:0] im_waddr,
   output logic [WIDTH-1:0]      im_wdata,
   output logic                  cpu_stall,
   output logic                  pc_load,
   output logic [31:0]           pc_init,
   output logic                  done,
   output logic                  err,
   output logic [ADDR_WIDTH:0]   word_count
);

   localparam int CW = ADDR_WIDTH + 1;
   localparam logic [ADDR_WIDTH:0] NUM_C  = CW'(NUM);
   localparam logic [ADDR_WIDTH:0] LAST_C = CW'(NUM - 1);

   typedef enum logic [2:0] {
      IDLE, CLEAR, LOAD, LAUNCH, RUN, ERROR
   } state_t;

   state_t              state;
   logic [ADDR_WIDTH:0] cnt;
   logic                xfer;
   logic                full;
   logic                sum_ok;

   assign pc_init = INIT_ADDRESS;

   // load_ready is registered and high exactly while in LOAD
   assign xfer = load_ready & load_valid;
   assign full = (cnt == NUM_C);

`ifdef IMEM_LOAD_CHECKSUM_EN
   logic [31:0] sum;
   logic [31:0] next_sum;
   assign next_sum = sum + 32'(load_data);
   assign sum_ok   = (next_sum == expected_sum);
`else
   assign sum_ok   = 1'b1;
`endif

   // Write port: clear writes zeros, load writes accepted words.
   // Gated by rst so nothing is written in a reset cycle.
   always_comb begin
      im_we    = 1'b0;
      im_waddr = cnt[ADDR_WIDTH-1:0];
      im_wdata = '0;
      if (!rst) begin
         if (state == CLEAR) begin
            im_we = 1'b1;
         end else if (xfer && !full) begin
            im_we    = 1'b1;
            im_wdata = load_data;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         cnt        <= '0;
         word_count <= '0;
         cpu_stall  <= 1'b1;
         load_ready <= 1'b0;
         pc_load    <= 1'b0;
         done       <= 1'b0;
         err        <= 1'b0;
`ifdef IMEM_LOAD_CHECKSUM_EN
         sum        <= '0;
         chk_err    <= 1'b0;
`endif
      end else begin
         pc_load <= 1'b0;
         unique case (state)
            IDLE, RUN, ERROR: begin
               if (start) begin
                  state      <= CLEAR;
                  cnt        <= '0;
                  word_count <= '0;
                  cpu_stall  <= 1'b1;
                  done       <= 1'b0;
                  err        <= 1'b0;
                  load_ready <= 1'b0;
`ifdef IMEM_LOAD_CHECKSUM_EN
                  sum        <= '0;
                  chk_err    <= 1'b0;
`endif
               end
            end
            CLEAR: begin
               cnt <= cnt + 1'b1;
               if (cnt == LAST_C) begin
                  state      <= LOAD;
                  cnt        <= '0;
                  load_ready <= 1'b1;
               end
            end
            LOAD: begin
               if (xfer) begin
                  if (full) begin
                     // program longer than the memory
                     state      <= ERROR;
                     err        <= 1'b1;
                     load_ready <= 1'b0;
                  end else begin
                     cnt        <= cnt + 1'b1;
                     word_count <= cnt + 1'b1;
`ifdef IMEM_LOAD_CHECKSUM_EN
                     sum        <= next_sum;
`endif
                     if (load_last) begin
                        load_ready <= 1'b0;
                        if (sum_ok) begin
                           state   <= LAUNCH;
                           pc_load <= 1'b1;
                        end else begin
                           state   <= ERROR;
                           err     <= 1'b1;
`ifdef IMEM_LOAD_CHECKSUM_EN
                           chk_err <= 1'b1;
`endif
                        end
                     end
                  end
               end
            end
            LAUNCH: begin
               state     <= RUN;
               cpu_stall <= 1'b0;
               done      <= 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
